// File: rtl/s_csub4_seq_if.sv
// Handshake bus for the bit-serial signed subtractor: operand side (in_*, s, a)
// and result side (out_*, b, ovf).
interface s_csub4_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] s;
    logic [3:0] a;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] b;
    logic       ovf;

    modport master (
        output in_valid, s, a, out_ready,
        input  in_ready, out_valid, b, ovf
    );

    modport slave (
        input  in_valid, s, a, out_ready,
        output in_ready, out_valid, b, ovf
    );
endinterface

// File: rtl/s_csub4_seq.sv
// Bit-serial signed subtractor: recovers b = s - a (6-bit exact) LSB first,
// one bit per clock, and flags results that do not fit in signed 4 bits.
module s_csub4_seq (
    input  logic           clk,
    input  logic           rst,
    s_csub4_seq_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_reg;
    logic [2:0] cnt_reg;
    logic       carry_reg;
    logic [5:0] s6_reg;
    logic [5:0] a6_reg;
    logic [5:0] diff_reg;
    logic [3:0] b_reg;
    logic       ovf_reg;
    logic       out_valid_reg;

    logic       a_inv_next;
    logic       sum_next;
    logic       carry_next;
    logic [5:0] diff_next;

    // Operands shift right so bit 0 is always the bit being processed;
    // result bits enter at the MSB and land in place after six shifts.
    always_comb begin
        a_inv_next = ~a6_reg[0];
        sum_next   = s6_reg[0] ^ a_inv_next ^ carry_reg;
        carry_next = (s6_reg[0] & a_inv_next) | (s6_reg[0] & carry_reg) |
                     (a_inv_next & carry_reg);
        diff_next  = {sum_next, diff_reg[5:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 3'd0;
            carry_reg     <= 1'b0;
            s6_reg        <= 6'd0;
            a6_reg        <= 6'd0;
            diff_reg      <= 6'd0;
            b_reg         <= 4'd0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        s6_reg    <= {bus.s[4], bus.s};
                        a6_reg    <= {{2{bus.a[3]}}, bus.a};
                        cnt_reg   <= 3'd0;
                        carry_reg <= 1'b1;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    s6_reg    <= {1'b0, s6_reg[5:1]};
                    a6_reg    <= {1'b0, a6_reg[5:1]};
                    diff_reg  <= diff_next;
                    carry_reg <= carry_next;
                    cnt_reg   <= cnt_reg + 3'd1;
                    if (cnt_reg == 3'd5) begin
                        // Representable in 4 bits only when the top three bits agree.
                        b_reg         <= diff_next[3:0];
                        ovf_reg       <= !((diff_next[5] == diff_next[4]) &&
                                           (diff_next[4] == diff_next[3]));
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.b         = b_reg;
    assign bus.ovf       = ovf_reg;
endmodule

// File: doc/s_csub4_seq.md
S_CSUB4_SEQ -- requirements
Module: s_csub4_seq

Interface
REQ-001 Parameters SHALL be none; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  upstream asserts when s and a are valid.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 s  input  5  signed two's-complement sum, in the format produced by the team's 4-bit signed CLA adder.
REQ-007 a  input  4  signed two's-complement known addend.
REQ-008 out_valid  output  1  b and ovf hold a completed result.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 b  output  4  recovered operand, diff[3:0].
REQ-011 ovf  output  1  set when the difference is not representable in signed 4 bits.

Function
REQ-012 The block SHALL compute diff = sext6(s) - sext6(a) as s + ~a + 1, bit-serially LSB first, with a 1-bit carry register initialised to 1.
- Range: diff is -23..+23; 6 bits are exact.
REQ-013 FSM states SHALL be IDLE, CALC and DONE.
- Any state other than these SHALL map to IDLE.
REQ-014 in_ready SHALL equal 1 exactly when the state is IDLE.
REQ-015 Accept: on an edge with in_valid=1 and in_ready=1, the block SHALL:
- capture s and a, sign-extended to 6 bits;
- clear the bit counter;
- set carry=1;
- enter CALC.
REQ-016 CALC processing SHALL be as follows:
- Each edge processes one bit i (counter 0..5): sum bit = s6[i] ^ ~a6[i] ^ carry, and carry is updated to the majority of those three terms.
- The counter increments each edge.
- After bit 5, the state SHALL become DONE.
REQ-017 Latency: out_valid SHALL rise on the 6th rising edge after the accepting edge.
REQ-018 In DONE, outputs SHALL be:
- out_valid=1;
- b=diff[3:0];
- ovf=1 when diff[5:3] is not all equal, otherwise 0.
REQ-019 b, ovf and out_valid SHALL remain stable in DONE until an edge with out_ready=1; the state then SHALL return to IDLE.
REQ-020 After leaving DONE, b and ovf SHALL hold their last values; out_valid SHALL be 0.
REQ-021 in_valid outside IDLE SHALL be ignored and SHALL have no effect on state or data.
- Input changes during CALC SHALL NOT affect the result, because the operands are captured.
REQ-022 Minimum issue interval SHALL be 8 cycles: accept, 6 CALC edges, 1 DONE handshake edge.
- There is no bypass from DONE to accept.
REQ-023 out_ready while not in DONE SHALL be ignored.
REQ-024 For any s = a + x, with x a signed 4-bit value and s exact in 5 bits, the block SHALL return b = x and ovf = 0.

Reset
REQ-025 On rst=1, regardless of clk, the block SHALL immediately:
- enter IDLE;
- clear counter, carry, operand and result registers;
- drive out_valid=0, b=4'b0000, ovf=0 and in_ready=1.
REQ-026 Reset asserted mid-CALC or in DONE SHALL discard the operation.
- The first accept after rst deasserts SHALL compute correctly.

Verification
REQ-027 s=5'b00101 (+5), a=4'b0011 (+3) -> 6 edges after accept: out_valid=1, b=4'b0010, ovf=0.
REQ-028 s=5'b10000 (-16), a=4'b0111 (+7) -> diff=-23: b=4'b1001, ovf=1.
REQ-029 s=5'b11111 (-1), a=4'b1000 (-8) -> b=4'b0111, ovf=0.
REQ-030 Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and the inputs -> b, ovf and out_valid stay stable and in_ready=0.
- Release out_ready -> IDLE next cycle; next accept at the earliest 8 cycles after the previous one.
REQ-031 Assert rst asynchronously at CALC bit 3 -> outputs reach their reset values without a clock edge.
- Then s=5'b01110, a=4'b0111 -> b=4'b0111, ovf=0.
REQ-032 Exhaustive: all 256 (a, x) pairs with s = a + x from a golden 5-bit signed adder -> b = x, ovf=0.
- Random out_ready stalls.
